pe_outcha_pair_scheduler: RTL and testbench



---
 rtl/pe_outcha_pair_scheduler.sv | 172 +++++++++++++++++
 tb/tb_pe_outcha_pair_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_outcha_pair_scheduler.sv
// pe_outcha_pair_scheduler
//
// Sequences one frame of output pixels for a dual-lane PE output channel.
// Pixels are issued as raster-ordered pairs: lane A carries the even pixel
// and lane B carries the odd pixel. Each issue is followed by a one-cycle gap
// so the pair-to-serial output buffer can drain lane B. When the frame has an
// odd pixel count, the final issue carries a lone pixel and is flagged.
//
// Optional feature: define PE_PAIR_SCHED_STALL_CNT_EN to add o_stall_cnt.
//
// Ports:
//   clk           clock; all state updates on its rising edge
//   rst           asynchronous active-high reset
//   i_start       one-cycle frame start request; honoured only in IDLE
//   i_ready       PE array / output buffer can accept a pair this cycle
//   o_pair_valid  a pair is issued this cycle
//   o_last_odd    qualifies o_pair_valid: lone final pixel on lane A
//   o_row         output row of the pair's even pixel
//   o_col         output column of the pair's even pixel
//   o_busy        high while the frame is being issued (ISSUE or GAP)
//   o_done        one-cycle pulse once the frame is fully issued
//   o_stall_cnt   (optional) cycles spent in ISSUE with i_ready low

module pe_outcha_pair_scheduler #(
    parameter int IN_WIDTH   = 513,
    parameter int IN_HEIGHT  = 257,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int DILATION_0 = 2,
    parameter int DILATION_1 = 2,
    parameter int PADDING_0  = 2,
    parameter int PADDING_1  = 2,
    parameter int STRIDE_0   = 1,
    parameter int STRIDE_1   = 1,
    localparam int OUT_HEIGHT =
        (IN_HEIGHT + 2*PADDING_0 - DILATION_0*(KERNEL_0-1) - 1) / STRIDE_0 + 1,
    localparam int OUT_WIDTH =
        (IN_WIDTH + 2*PADDING_1 - DILATION_1*(KERNEL_1-1) - 1) / STRIDE_1 + 1,
    localparam int OUT_PIXELS = OUT_HEIGHT * OUT_WIDTH,
    localparam int PAIRS      = (OUT_PIXELS + 1) / 2,
    localparam int ROW_W      = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1,
    localparam int COL_W      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1,
    localparam int CNT_W      = $clog2(PAIRS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_ready,
    output logic             o_pair_valid,
    output logic             o_last_odd,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_busy,
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
    output logic             o_done,
    output logic [31:0]      o_stall_cnt
`else
    output logic             o_done
`endif
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam bit             OddFrame = (OUT_PIXELS % 2) == 1;
    localparam logic [CNT_W-1:0] LastPairIdx = CNT_W'(PAIRS - 1);
    localparam logic [CNT_W-1:0] PairsL      = CNT_W'(PAIRS);
    localparam logic [COL_W:0]   OutWidthL   = (COL_W+1)'(OUT_WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    logic             w_issue;
    logic             w_final;
    logic             w_accept_start;
    logic [COL_W:0]   w_col_p2;
    logic [ROW_W-1:0] w_row_next;
    logic [COL_W-1:0] w_col_next;

    assign w_issue        = (r_state == StIssue) && i_ready;
    assign w_final        = (r_cnt == LastPairIdx);
    assign w_accept_start = (r_state == StIdle) && i_start;

    // One extra bit so col+2 cannot wrap before the row-boundary compare.
    assign w_col_p2 = {1'b0, r_col} + (COL_W+1)'(2);

    always_comb begin
        w_row_next = r_row;
        w_col_next = r_col;
        if (w_col_p2 < OutWidthL) begin
            w_col_next = w_col_p2[COL_W-1:0];
        end else begin
            // Modular subtraction is exact: the true result is below OUT_WIDTH.
            w_col_next = r_col + COL_W'(2) - COL_W'(OUT_WIDTH);
            w_row_next = r_row + ROW_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StIssue;
            end
            StIssue: begin
                if (i_ready) begin
                    // A lone final pixel needs no drain gap for lane B.
                    w_state_next = (w_final && OddFrame) ? StDone : StGap;
                end
            end
            StGap: begin
                // Counter reaches PAIRS only after the final pair was issued.
                w_state_next = (r_cnt == PairsL) ? StDone : StIssue;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept_start) begin
                r_cnt <= '0;
                r_row <= '0;
                r_col <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_row <= w_row_next;
                r_col <= w_col_next;
            end
        end
    end

`ifdef PE_PAIR_SCHED_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept_start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StIssue) && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_pair_valid = w_issue;
    assign o_last_odd   = w_issue && w_final && OddFrame;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_busy       = (r_state == StIssue) || (r_state == StGap);
    assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_pe_outcha_pair_scheduler.sv
// Scoreboard bench for pe_outcha_pair_scheduler.
// Two instances: an odd 5x3 output frame and an even 4x2 output frame.
// Stimulus pushes expected issues/done pulses; a negedge monitor pops them.

module tb_pe_outcha_pair_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Odd instance: IN 5x3, K=3, D=1, P=1, S=1 -> 5 wide x 3 high.
    logic       start_o = 1'b0, ready_o = 1'b1;
    logic       pv_o, lo_o, busy_o, done_o;
    logic [1:0] row_o;
    logic [2:0] col_o;
    // Even instance: IN 4x2, K=1, D=1, P=0, S=1 -> 4 wide x 2 high.
    logic       start_e = 1'b0, ready_e = 1'b1;
    logic       pv_e, lo_e, busy_e, done_e;
    logic [0:0] row_e;
    logic [1:0] col_e;
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
    logic [31:0] stall_o, stall_e;
`endif

    pe_outcha_pair_scheduler #(
        .IN_WIDTH(5), .IN_HEIGHT(3), .KERNEL_0(3), .KERNEL_1(3),
        .DILATION_0(1), .DILATION_1(1), .PADDING_0(1), .PADDING_1(1),
        .STRIDE_0(1), .STRIDE_1(1)
    ) dut_odd (
        .clk(clk), .rst(rst), .i_start(start_o), .i_ready(ready_o),
        .o_pair_valid(pv_o), .o_last_odd(lo_o), .o_row(row_o), .o_col(col_o),
        .o_busy(busy_o),
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
        .o_done(done_o), .o_stall_cnt(stall_o)
`else
        .o_done(done_o)
`endif
    );

    pe_outcha_pair_scheduler #(
        .IN_WIDTH(4), .IN_HEIGHT(2), .KERNEL_0(1), .KERNEL_1(1),
        .DILATION_0(1), .DILATION_1(1), .PADDING_0(0), .PADDING_1(0),
        .STRIDE_0(1), .STRIDE_1(1)
    ) dut_even (
        .clk(clk), .rst(rst), .i_start(start_e), .i_ready(ready_e),
        .o_pair_valid(pv_e), .o_last_odd(lo_e), .o_row(row_e), .o_col(col_e),
        .o_busy(busy_e),
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
        .o_done(done_e), .o_stall_cnt(stall_e)
`else
        .o_done(done_e)
`endif
    );

    typedef struct {
        int id;    // 0 = odd instance, 1 = even instance
        int kind;  // 0 = pair issue, 1 = done pulse
        int cyc;
        int row;
        int col;
        int last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    // Hand-computed raster pair positions.
    int odd_row[8]  = '{0, 0, 0, 1, 1, 2, 2, 2};
    int odd_col[8]  = '{0, 2, 4, 1, 3, 0, 2, 4};
    int even_row[4] = '{0, 0, 1, 1};
    int even_col[4] = '{0, 2, 0, 2};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(input int id, input int kind, input int c, input int r,
                        input int col, input int last);
        exp_t e;
        e.id = id; e.kind = kind; e.cyc = c; e.row = r; e.col = col; e.last = last;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int id, input int kind, input int row, input int col,
                           input int last);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got dut %0d kind %0d expected none (cycle %0d)",
                     id, kind, cyc);
        end else begin
            e = q.pop_front();
            check("event_dut", id, e.id);
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (kind == 0) begin
                check("issue_row", row, e.row);
                check("issue_col", col, e.col);
                check("issue_last_odd", last, e.last);
            end
        end
    endtask

    task automatic mon_dut(input int id, input logic pv, input logic lo, input int row,
                           input int col, input logic done);
        if (!pv) check("last_odd_without_valid", {31'd0, lo}, 32'd0);
        if (pv) pop_cmp(id, 0, row, col, int'(lo));
        if (done) pop_cmp(id, 1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_dut(0, pv_o, lo_o, int'(row_o), int'(col_o), done_o);
            mon_dut(1, pv_e, lo_e, int'(row_e), int'(col_e), done_e);
        end
    end

    task automatic set_in(input int id, input logic s, input logic r);
        if (id == 0) begin start_o = s; ready_o = r; end
        else begin start_e = s; ready_e = r; end
    endtask

    // Runs one frame; stall window [stall_lo,stall_hi] and the extra start
    // pulse are relative to the start cycle. rst_at >= 0 aborts with reset.
    task automatic run_frame(input int id, input int stall_lo, input int stall_hi,
                             input int extra_start, input int rst_at);
        int t0, k, shift, n, rdy;
        shift = (stall_hi >= stall_lo) ? (stall_hi - stall_lo + 1) : 0;
        n = (id == 0) ? 8 : 4;
        @(posedge clk); #1;
        t0 = cyc;
        set_in(id, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            int c = t0 + 1 + 2*i + ((i > 0) ? shift : 0);
            if (rst_at < 0 || (c - t0) < rst_at) begin
                if (id == 0) push(0, 0, c, odd_row[i], odd_col[i], (i == 7) ? 1 : 0);
                else push(1, 0, c, even_row[i], even_col[i], 0);
            end
        end
        if (rst_at < 0) push(id, 1, t0 + ((id == 0) ? 16 : 9) + shift, 0, 0, 0);
        @(posedge clk); #1;
        while ((cyc - t0) <= 26) begin
            k = cyc - t0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", {31'd0, busy_o}, 32'd0);
                check("rst_valid", {31'd0, pv_o}, 32'd0);
                check("rst_done", {31'd0, done_o}, 32'd0);
                check("rst_row", {30'd0, row_o}, 32'd0);
                check("rst_col", {29'd0, col_o}, 32'd0);
                break;
            end
            rdy = (k >= stall_lo && k <= stall_hi) ? 0 : 1;
            set_in(id, (k == extra_start) ? 1'b1 : 1'b0, rdy[0]);
            @(posedge clk); #1;
        end
        set_in(id, 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        int budget = 60;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (4) @(posedge clk);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_valid", {31'd0, pv_o}, 32'd0);
        check("reset_row", {30'd0, row_o}, 32'd0);
        check("reset_col", {29'd0, col_o}, 32'd0);
        check("reset_busy_even", {31'd0, busy_e}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Stall frame first so the later clear-on-start is observable.
        run_frame(0, 3, 6, -1, -1);
        wait_drain();
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
        check("stall_cnt_after_stall", stall_o, 32'd4);
`endif

        // Plain odd frame.
        run_frame(0, 1, 0, -1, -1);
        wait_drain();
`ifdef PE_PAIR_SCHED_STALL_CNT_EN
        check("stall_cnt_cleared", stall_o, 32'd0);
`endif

        // Even frame.
        run_frame(1, 1, 0, -1, -1);
        wait_drain();

        // Start pulse mid-frame is ignored.
        run_frame(0, 1, 0, 4, -1);
        wait_drain();

        // Reset mid-frame, then a clean frame.
        run_frame(0, 1, 0, -1, 6);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_drain();
        run_frame(0, 1, 0, -1, -1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
